// File: rtl/avalon_pio_pkg.sv
// Shared definitions for the Avalon-MM parallel I/O block.
// Contents: register word addresses and the edge-capture mode enum,
// plus a helper that maps the integer EDGE_TYPE parameter onto the enum.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    // Unknown encodings fall back to rising-edge capture.
    function automatic edge_mode_e to_edge_mode(input int edge_type);
        case (edge_type)
            1:       return EDGE_FALL;
            2:       return EDGE_ANY;
            default: return EDGE_RISE;
        endcase
    endfunction

endpackage

// File: rtl/pio_sync.sv
// Multi-flop synchronizer for asynchronous input bits.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset (flops clear to 0)
//   d            : asynchronous input vector, WIDTH bits
//   q            : synchronized output, DEPTH flops after d
module pio_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    // NOTE: non-blocking assignments make every stage sample its predecessor's
    // old value, so the chain shifts by exactly one flop per clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], d};
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/avalon_pio_ext.sv
// Avalon-MM parallel I/O port with direction control, set/clear output
// aliases, per-bit edge capture and a maskable level interrupt.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave write/select inputs
//   readdata              : zero-latency combinational read data
//   in_port               : asynchronous external inputs
//   out_port              : output data register
//   oe                    : direction register, 1 = bit driven as output
//   irq                   : level interrupt, |(edgecap & mask)
module avalon_pio_ext
    import avalon_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);

    localparam edge_mode_e EDGE_MODE = to_edge_mode(EDGE_TYPE);
    // Edges counted after internal reset release before in_prev holds a
    // genuine in_port sample rather than the synchronizer's reset zeros.
    localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

    logic [1:0]            rst_pipe;
    logic                  rst_n_int;
    logic [2:0]            arm_cnt;
    logic                  armed;
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] in_prev;
    logic [DATA_WIDTH-1:0] edge_hit;
    logic [DATA_WIDTH-1:0] out_reg;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] edgecap;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] cap_clr;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  wr_en;
    logic                  unused_wdata;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end
    assign rst_n_int = rst_pipe[1];

    pio_sync #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (rst_n_int),
        .d       (in_port),
        .q       (in_sync)
    );

    // Edge capture stays disarmed until the synchronizer and in_prev have
    // both been refilled from in_port, so reset zeros never look like edges.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 3'd1;
        end
    end
    assign armed = (arm_cnt == ARM_COUNT);

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign cap_clr      = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

    always_comb begin
        edge_hit = '0;
        case (EDGE_MODE)
            EDGE_RISE: edge_hit = in_sync & ~in_prev;
            EDGE_FALL: edge_hit = ~in_sync & in_prev;
            EDGE_ANY:  edge_hit = in_sync ^ in_prev;
            default:   edge_hit = '0;
        endcase
        if (!armed) begin
            edge_hit = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            out_reg <= RESET_VALUE;
            oe      <= '0;
            mask    <= '0;
            edgecap <= '0;
            in_prev <= '0;
        end else begin
            in_prev <= in_sync;
            // OR-ing the new edges in after the clear lets a same-cycle
            // edge win over a W1C to that bit.
            edgecap <= (edgecap & ~cap_clr) | edge_hit;
            if (wr_en) begin
                case (address)
                    ADDR_DATA:    out_reg <= wdata;
                    ADDR_DIR:     oe      <= wdata;
                    ADDR_IRQMASK: mask    <= wdata;
                    ADDR_OUTSET:  out_reg <= out_reg | wdata;
                    ADDR_OUTCLR:  out_reg <= out_reg & ~wdata;
                    default:      ;
                endcase
            end
        end
    end

    // NOTE: rd_val gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:    rd_val = (oe & out_reg) | (~oe & in_sync);
            ADDR_DIR:     rd_val = oe;
            ADDR_IRQMASK: rd_val = mask;
            ADDR_EDGECAP: rd_val = edgecap;
            default:      rd_val = '0;
        endcase
    end

    assign readdata = 32'(rd_val);
    assign out_port = out_reg;
    assign irq      = |(edgecap & mask);

endmodule

// File: tb/tb_avalon_pio_ext.sv
module tb_avalon_pio_ext;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;

    logic [31:0] rd   [3];
    logic [7:0]  outp [3];
    logic [7:0]  oev  [3];
    logic        irqv [3];
    logic [31:0] rdcap[3];

    // Instance configuration: 0 rising/2 stages, 1 falling/2 stages with a
    // non-zero reset value, 2 any-edge/3 stages.
    int         mode_of [3] = '{0, 1, 2};
    int         sync_of [3] = '{2, 2, 3};
    logic [7:0] rv_of   [3] = '{8'h00, 8'h3C, 8'h00};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [7:0] m_out [3];
    logic [7:0] m_ecap[3];
    logic [7:0] m_oe;
    logic [7:0] m_mask;
    logic [7:0] samp[$];   // in_port value seen at each clock edge, oldest first

    always #5 clk = ~clk;

    avalon_pio_ext #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[0]), .in_port(in_port),
        .out_port(outp[0]), .oe(oev[0]), .irq(irqv[0]));

    avalon_pio_ext #(.DATA_WIDTH(8), .RESET_VALUE(8'h3C), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[1]), .in_port(in_port),
        .out_port(outp[1]), .oe(oev[1]), .irq(irqv[1]));

    avalon_pio_ext #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .EDGE_TYPE(2), .SYNC_STAGES(3)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[2]), .in_port(in_port),
        .out_port(outp[2]), .oe(oev[2]), .irq(irqv[2]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] edges_of(input int mode, input logic [7:0] cur, input logic [7:0] prev);
        case (mode)
            0:       return cur & ~prev;
            1:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    task automatic model_reset(input logic [7:0] pin);
        for (int i = 0; i < 3; i++) begin
            m_out[i]  = rv_of[i];
            m_ecap[i] = 8'h00;
        end
        m_oe   = 8'h00;
        m_mask = 8'h00;
        samp.delete();
        repeat (6) samp.push_back(pin);
    endtask

    // The value an instance sees as "synchronized input" lags in_port by
    // sync_of clock edges; the edge detector compares that against one more.
    task automatic model_edge(input logic cs, input logic wn, input logic [2:0] a,
                              input logic [31:0] wd, input logic [7:0] pin);
        logic [7:0] d8;
        logic       wr;
        d8 = wd[7:0];
        wr = cs & ~wn;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] cur, prev, clr;
            cur  = samp[samp.size() - sync_of[i]];
            prev = samp[samp.size() - sync_of[i] - 1];
            clr  = (wr && a == 3'd3) ? d8 : 8'h00;
            m_ecap[i] = (m_ecap[i] & ~clr) | edges_of(mode_of[i], cur, prev);
            if (wr) begin
                if (a == 3'd0) m_out[i] = d8;
                if (a == 3'd4) m_out[i] = m_out[i] | d8;
                if (a == 3'd5) m_out[i] = m_out[i] & ~d8;
            end
        end
        if (wr && a == 3'd1) m_oe = d8;
        if (wr && a == 3'd2) m_mask = d8;
        samp.push_back(pin);
        if (samp.size() > 8) void'(samp.pop_front());
    endtask

    function automatic logic [31:0] m_read(input int i, input logic [2:0] a);
        logic [7:0] ins;
        ins = samp[samp.size() - sync_of[i]];
        case (a)
            3'd0:    return {24'h0, (m_oe & m_out[i]) | (~m_oe & ins)};
            3'd1:    return {24'h0, m_oe};
            3'd2:    return {24'h0, m_mask};
            3'd3:    return {24'h0, m_ecap[i]};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- bus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) rdcap[i] = rd[i];
        chipselect = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        in_port = 8'hFF;
        reset_n = 1'b0;
        idle(3);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (outp[i] !== rv_of[i]) begin
                n_bad++; $display("FAIL rst_out inst%0d: got %h want %h", i, outp[i], rv_of[i]);
            end
            n_cmp++;
            if (oev[i] !== 8'h00 || irqv[i] !== 1'b0) begin
                n_bad++; $display("FAIL rst_oe_irq inst%0d: oe %h irq %b want 00 0", i, oev[i], irqv[i]);
            end
        end
        address = 3'd0; #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rd[i] !== 32'h0) begin
                n_bad++; $display("FAIL rst_data inst%0d: got %h want 0", i, rd[i]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(12);
        // in_port was high through reset: no edge may be captured.
        bus_read(3'd3);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdcap[i] !== 32'h0 || irqv[i] !== 1'b0) begin
                n_bad++; $display("FAIL post_rst_edgecap inst%0d: got %h irq %b want 0", i, rdcap[i], irqv[i]);
            end
        end
        bus_read(3'd0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdcap[i] !== 32'h0000_00FF) begin
                n_bad++; $display("FAIL post_rst_data inst%0d: got %h want 000000ff", i, rdcap[i]);
            end
        end
    endtask

    task automatic test_set_clr;
        logic [7:0] exp_v [3] = '{8'h5A, 8'hDB, 8'hC3};
        logic [2:0] adr   [3] = '{3'd0, 3'd4, 3'd5};
        logic [7:0] dat   [3] = '{8'h5A, 8'h81, 8'h18};
        for (int s = 0; s < 3; s++) begin
            bus_write(adr[s], {24'hABCDEF, dat[s]});
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (outp[i] !== exp_v[s]) begin
                    n_bad++; $display("FAIL set_clr step%0d inst%0d: got %h want %h", s, i, outp[i], exp_v[s]);
                end
            end
        end
        bus_read(3'd4);
        n_cmp++;
        if (rdcap[0] !== 32'h0) begin
            n_bad++; $display("FAIL outset_read: got %h want 0", rdcap[0]);
        end
    endtask

    task automatic test_data_read;
        bus_write(3'd1, 32'hF0);
        bus_write(3'd0, 32'hA5);
        @(negedge clk);
        in_port = 8'h3C;
        idle(6);
        bus_read(3'd0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdcap[i] !== 32'h0000_00AC) begin
                n_bad++; $display("FAIL data_read inst%0d: got %h want 000000ac", i, rdcap[i]);
            end
        end
        bus_read(3'd1);
        n_cmp++;
        if (rdcap[0] !== 32'h0000_00F0) begin
            n_bad++; $display("FAIL dir_read: got %h want 000000f0", rdcap[0]);
        end
    endtask

    task automatic test_edge_latency;
        idle(6);
        bus_write(3'd2, 32'h01);
        bus_write(3'd3, 32'hFF);
        n_cmp++;
        if (irqv[0] !== 1'b0) begin
            n_bad++; $display("FAIL latency_pre irq: got %b want 0", irqv[0]);
        end
        @(negedge clk);
        in_port[0] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (irqv[0] !== (e == 3)) begin
                n_bad++; $display("FAIL latency edge%0d irq: got %b want %b", e, irqv[0], e == 3);
            end
        end
        bus_read(3'd3);
        n_cmp++;
        if (rdcap[0] !== 32'h1) begin
            n_bad++; $display("FAIL latency_edgecap: got %h want 1", rdcap[0]);
        end
        bus_write(3'd3, 32'h01);
        n_cmp++;
        if (irqv[0] !== 1'b0) begin
            n_bad++; $display("FAIL w1c irq: got %b want 0", irqv[0]);
        end
    endtask

    task automatic test_set_wins;
        @(negedge clk);
        in_port[0] = 1'b0;
        idle(6);
        n_cmp++;
        if (irqv[0] !== 1'b0) begin
            n_bad++; $display("FAIL fall_ignored irq: got %b want 0", irqv[0]);
        end
        @(negedge clk);
        in_port[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        n_cmp++;
        if (irqv[0] !== 1'b0) begin
            n_bad++; $display("FAIL set_wins_pre irq: got %b want 0", irqv[0]);
        end
        bus_write(3'd3, 32'h01);   // clear lands on the same edge as the set
        n_cmp++;
        if (irqv[0] !== 1'b1) begin
            n_bad++; $display("FAIL set_wins irq: got %b want 1", irqv[0]);
        end
        bus_read(3'd3);
        n_cmp++;
        if (rdcap[0] !== 32'h1) begin
            n_bad++; $display("FAIL set_wins edgecap: got %h want 1", rdcap[0]);
        end
    endtask

    task automatic test_any_edge;
        logic [31:0] exp_cap [3] = '{32'h00, 32'h08, 32'h08};
        logic        exp_irq [3] = '{1'b0, 1'b1, 1'b1};
        bus_write(3'd2, 32'h00);
        @(negedge clk);
        in_port[3] = 1'b1;
        idle(8);
        bus_write(3'd3, 32'hFF);
        @(negedge clk);
        in_port[3] = 1'b0;
        idle(8);
        bus_read(3'd3);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdcap[i] !== exp_cap[i] || irqv[i] !== 1'b0) begin
                n_bad++; $display("FAIL any_edge inst%0d: cap %h irq %b want %h 0", i, rdcap[i], irqv[i], exp_cap[i]);
            end
        end
        bus_write(3'd2, 32'h08);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (irqv[i] !== exp_irq[i]) begin
                n_bad++; $display("FAIL mask_irq inst%0d: got %b want %b", i, irqv[i], exp_irq[i]);
            end
        end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        in_port = 8'h00;
        idle(8);
        bus_write(3'd3, 32'hFF);
        bus_write(3'd0, 32'hFF);
        @(negedge clk);
        in_port = 8'h0F;
        idle(8);
        bus_write(3'd2, 32'h0F);
        bus_read(3'd3);
        n_cmp++;
        if (rdcap[0] !== 32'h0F || irqv[0] !== 1'b1 || outp[0] !== 8'hFF) begin
            n_bad++; $display("FAIL midop_pre: cap %h irq %b out %h want 0f 1 ff", rdcap[0], irqv[0], outp[0]);
        end
        @(negedge clk);
        address = 3'd3;
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (outp[i] !== rv_of[i] || rd[i] !== 32'h0 || irqv[i] !== 1'b0) begin
                n_bad++; $display("FAIL midop_rst inst%0d: out %h cap %h irq %b want %h 0 0", i, outp[i], rd[i], irqv[i], rv_of[i]);
            end
        end
        address = 3'd6;
        #1;
        n_cmp++;
        if (rd[0] !== 32'h0) begin
            n_bad++; $display("FAIL addr6_read: got %h want 0", rd[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(10);
    endtask

    task automatic test_random;
        int         op;
        logic [2:0] a;
        logic [31:0] d;
        @(negedge clk);
        in_port = 8'($urandom);
        reset_n = 1'b0;
        idle(2);
        @(negedge clk);
        reset_n = 1'b1;
        idle(10);
        model_reset(in_port);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (outp[i] !== m_out[i] || oev[i] !== m_oe || irqv[i] !== |(m_ecap[i] & m_mask)) begin
                    n_bad++;
                    $display("FAIL rand_out c%0d inst%0d: out %h oe %h irq %b want %h %h %b",
                             c, i, outp[i], oev[i], irqv[i], m_out[i], m_oe, |(m_ecap[i] & m_mask));
                end
            end
            if ($urandom_range(0, 2) == 0) in_port = in_port ^ 8'($urandom);
            op = $urandom_range(0, 2);
            a  = 3'($urandom);
            d  = $urandom;
            address    = a;
            writedata  = d;
            chipselect = (op != 0);
            write_n    = (op != 2);
            if (op == 1) begin
                #1;
                for (int i = 0; i < 3; i++) begin
                    n_cmp++;
                    if (rd[i] !== m_read(i, a)) begin
                        n_bad++;
                        $display("FAIL rand_read c%0d inst%0d addr%0d: got %h want %h", c, i, a, rd[i], m_read(i, a));
                    end
                end
            end
            @(posedge clk);
            model_edge(chipselect, write_n, address, writedata, in_port);
        end
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        test_reset();
        test_set_clr();
        test_data_read();
        test_edge_latency();
        test_set_wins();
        test_any_edge();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
